mux_nx1_rr: RTL

Parametrised N-input, W-bit registered multiplexer with per-channel valid/ready handshakes and a single registered output stage. Selects a source either by an external select (fixed mode, the direct successor of the 4:1 behavioural mux) or by round-robin arbitration among requesting channels. Sits between multiple producers and a single consumer wherever a shared datapath needs backpressure and fair access.

---
 rtl/mux_nx1_rr.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux_nx1_rr.sv
// N:1 registered mux with per-channel valid/ready. Mode 0 picks the channel named
// by sel, mode 1 arbitrates round-robin among requesting channels.
module mux_nx1_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0][W-1:0] chan_data;
  logic [2*N-1:0]      rot;
  logic [SW:0]         sum;
  logic [SW-1:0]       g;
  logic                gnt, free, xfer_in;

  logic                vld_q, vld_d;
  logic [W-1:0]        data_q, data_d;
  logic [SW-1:0]       ch_q, ch_d;
  logic [SW-1:0]       ptr_q, ptr_d;

  assign chan_data = in_data;
  assign free      = !vld_q || out_ready;
  assign xfer_in   = gnt && free;

  // Round-robin: rotate requests so bit 0 is the channel at ptr, take the
  // lowest set bit, then map the offset back to an absolute channel index.
  always_comb begin
    g   = '0;
    gnt = 1'b0;
    sum = '0;
    rot = {in_valid, in_valid} >> ptr_q;
    if (!mode) begin
      for (int k = 0; k < N; k++) begin
        if (sel == SW'(k) && in_valid[k]) begin
          g   = SW'(k);
          gnt = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!gnt && rot[i]) begin
          gnt = 1'b1;
          sum = {1'b0, ptr_q} + (SW+1)'(i);
          g   = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N)) : SW'(sum);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++)
      in_ready[k] = rst_n && xfer_in && (g == SW'(k));
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ch_d   = ch_q;
    ptr_d  = ptr_q;
    if (xfer_in) begin
      vld_d = 1'b1;
      ch_d  = g;
      for (int k = 0; k < N; k++)
        if (g == SW'(k)) data_d = chan_data[k];
      if (mode) ptr_d = (g == SW'(N-1)) ? '0 : g + SW'(1);
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule
